issue_ctrl: RTL and testbench

Scoreboard-based issue controller between the instruction-decode stage and the execute stage. Tracks outstanding register writes from issued instructions, stalls decode on RAW hazards against in-flight writers, and gates the decode→execute handshake. Handles pipeline-wide flush and one-cycle fetch kill after taken branches and jumps.

---
 rtl/issue_ctrl_pkg.sv | 11 +
 rtl/issue_sb_entry.sv | 32 +++
 rtl/issue_ctrl.sv | 89 ++++++++
 tb/tb_issue_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/issue_ctrl_pkg.sv
// Shared constants and types for the issue controller scoreboard.
// Optional build macro ISSUE_STAT_EN is consumed by issue_ctrl.
package issue_ctrl_pkg;

  localparam int NUM_REGS   = 32;
  localparam int REG_ADDR_W = 5;
  localparam int CNT_W      = 2;

  typedef logic [NUM_REGS-1:0][CNT_W-1:0] sb_cnt_t;

endpackage

// File: rtl/issue_sb_entry.sv
// One scoreboard entry: count of in-flight writes to a single register.
// Saturates at both ends; clear overrides increment and decrement.
module issue_sb_entry #(
  parameter int CNT_W = issue_ctrl_pkg::CNT_W
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_inc,
  input  logic             i_dec,
  output logic [CNT_W-1:0] o_cnt
);
  import issue_ctrl_pkg::*;

  logic [CNT_W-1:0] r_cnt;

  // A simultaneous issue and retirement leaves the count untouched.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && !i_dec && r_cnt != '1) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else if (i_dec && !i_inc && r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/issue_ctrl.sv
// Decode-to-execute issue controller with a per-register write scoreboard.
// Define ISSUE_STAT_EN to add the o_stall_cycles hazard-stall counter port.
module issue_ctrl #(
  parameter int NUM_REGS = issue_ctrl_pkg::NUM_REGS,
  parameter int CNT_W    = issue_ctrl_pkg::CNT_W
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic                              i_id_valid,
  output logic                              o_id_ready,
  input  logic                              i_r1_en,
  input  logic [issue_ctrl_pkg::REG_ADDR_W-1:0] i_r1_addr,
  input  logic                              i_r2_en,
  input  logic [issue_ctrl_pkg::REG_ADDR_W-1:0] i_r2_addr,
  input  logic                              i_rw_en,
  input  logic [issue_ctrl_pkg::REG_ADDR_W-1:0] i_rw_addr,
  input  logic                              i_br_taken,
  output logic                              o_ex_valid,
  input  logic                              i_ex_ready,
  input  logic                              i_wb_en,
  input  logic [issue_ctrl_pkg::REG_ADDR_W-1:0] i_wb_addr,
  input  logic                              i_flush,
  output logic                              o_if_kill
`ifdef ISSUE_STAT_EN
  ,
  output logic [31:0]                       o_stall_cycles
`endif
);
  import issue_ctrl_pkg::*;

  logic [NUM_REGS-1:0][CNT_W-1:0] w_cnt;
  logic w_busy1;
  logic w_busy2;
  logic w_full;
  logic w_hz;
  logic w_issue;
  logic r_if_kill;

  assign w_cnt[0] = '0;

  for (genvar g = 1; g < NUM_REGS; g++) begin : g_sb
    localparam logic [REG_ADDR_W-1:0] ADDR = REG_ADDR_W'(g);
    issue_sb_entry #(.CNT_W(CNT_W)) u_entry (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_clr   (i_flush),
      .i_inc   (w_issue && i_rw_en && i_rw_addr == ADDR),
      .i_dec   (i_wb_en && i_wb_addr == ADDR),
      .o_cnt   (w_cnt[g])
    );
  end

  // The regfile is write-first, so a last outstanding write retiring now is already readable.
  assign w_busy1 = (w_cnt[i_r1_addr] != '0) &&
                   !(w_cnt[i_r1_addr] == CNT_W'(1) && i_wb_en && i_wb_addr == i_r1_addr);
  assign w_busy2 = (w_cnt[i_r2_addr] != '0) &&
                   !(w_cnt[i_r2_addr] == CNT_W'(1) && i_wb_en && i_wb_addr == i_r2_addr);
  assign w_full  = i_rw_en && (i_rw_addr != '0) && (w_cnt[i_rw_addr] == '1);
  assign w_hz    = (i_r1_en && w_busy1) || (i_r2_en && w_busy2) || w_full;

  assign o_ex_valid = i_id_valid && !w_hz && !i_flush;
  assign o_id_ready = i_ex_ready && !w_hz && !i_flush;
  assign w_issue    = i_id_valid && o_id_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_if_kill <= 1'b0;
    end else begin
      r_if_kill <= !i_flush && w_issue && i_br_taken;
    end
  end

  assign o_if_kill = r_if_kill;

`ifdef ISSUE_STAT_EN
  logic [31:0] r_stall_cycles;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stall_cycles <= '0;
    end else if (i_id_valid && w_hz && !i_flush && r_stall_cycles != '1) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign o_stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_issue_ctrl.sv
// Self-checking bench for issue_ctrl: table-driven vectors through a scoreboard queue.
// Builds with or without ISSUE_STAT_EN.
module tb_issue_ctrl;

  typedef struct {
    logic       idValid;
    logic       exReady;
    logic       r1En;
    logic [4:0] r1Addr;
    logic       r2En;
    logic [4:0] r2Addr;
    logic       rwEn;
    logic [4:0] rwAddr;
    logic       brTaken;
    logic       wbEn;
    logic [4:0] wbAddr;
    logic       flush;
    logic       expExValid;
    logic       expIdReady;
    logic       expIfKill;
  } vec_t;

  typedef struct {
    logic exValid;
    logic idReady;
    logic ifKill;
  } exp_t;

  logic       clk = 1'b0;
  logic       rstN = 1'b0;
  logic       idValid = 1'b0;
  logic       idReady;
  logic       r1En = 1'b0;
  logic [4:0] r1Addr = '0;
  logic       r2En = 1'b0;
  logic [4:0] r2Addr = '0;
  logic       rwEn = 1'b0;
  logic [4:0] rwAddr = '0;
  logic       brTaken = 1'b0;
  logic       exValid;
  logic       exReady = 1'b0;
  logic       wbEn = 1'b0;
  logic [4:0] wbAddr = '0;
  logic       flush = 1'b0;
  logic       ifKill;
`ifdef ISSUE_STAT_EN
  logic [31:0] stallCycles;
`endif

  int   checks = 0;
  int   passes = 0;
  int   expStalls = 0;
  exp_t sbQueue[$];
  vec_t vecs[$];

  always #5 clk = ~clk;

  issue_ctrl dut (
    .i_clk        (clk),
    .i_rst_n      (rstN),
    .i_id_valid   (idValid),
    .o_id_ready   (idReady),
    .i_r1_en      (r1En),
    .i_r1_addr    (r1Addr),
    .i_r2_en      (r2En),
    .i_r2_addr    (r2Addr),
    .i_rw_en      (rwEn),
    .i_rw_addr    (rwAddr),
    .i_br_taken   (brTaken),
    .o_ex_valid   (exValid),
    .i_ex_ready   (exReady),
    .i_wb_en      (wbEn),
    .i_wb_addr    (wbAddr),
    .i_flush      (flush),
    .o_if_kill    (ifKill)
`ifdef ISSUE_STAT_EN
    ,
    .o_stall_cycles (stallCycles)
`endif
  );

  function automatic vec_t mk(input int iv, input int er, input int e1, input int a1,
                              input int e2, input int a2, input int ew, input int aw,
                              input int br, input int ewb, input int awb, input int fl,
                              input int xv, input int xr, input int xk);
    vec_t v;
    v.idValid = 1'(iv);  v.exReady = 1'(er);
    v.r1En = 1'(e1);     v.r1Addr = 5'(a1);
    v.r2En = 1'(e2);     v.r2Addr = 5'(a2);
    v.rwEn = 1'(ew);     v.rwAddr = 5'(aw);
    v.brTaken = 1'(br);  v.wbEn = 1'(ewb);  v.wbAddr = 5'(awb);
    v.flush = 1'(fl);
    v.expExValid = 1'(xv); v.expIdReady = 1'(xr); v.expIfKill = 1'(xk);
    return v;
  endfunction

  function automatic void check1(input string name, input logic got, input logic want);
    checks++;
    if (got === want) passes++;
    else $display("[TB] FAIL %s: got %b, expected %b", name, got, want);
  endfunction

  task automatic applyStimulus(input vec_t v);
    exp_t e;
    idValid = v.idValid; exReady = v.exReady;
    r1En = v.r1En; r1Addr = v.r1Addr;
    r2En = v.r2En; r2Addr = v.r2Addr;
    rwEn = v.rwEn; rwAddr = v.rwAddr;
    brTaken = v.brTaken; wbEn = v.wbEn; wbAddr = v.wbAddr;
    flush = v.flush;
    e.exValid = v.expExValid; e.idReady = v.expIdReady; e.ifKill = v.expIfKill;
    sbQueue.push_back(e);
    if (v.idValid && !v.flush && !v.expExValid) expStalls++;
  endtask

  task automatic checkOutput(input int idx);
    exp_t e;
    if (sbQueue.size() == 0) begin
      checks++;
      $display("[TB] FAIL scoreboard_empty step %0d: got 0 entries, expected 1", idx);
      return;
    end
    e = sbQueue.pop_front();
    check1($sformatf("ex_valid step %0d", idx), exValid, e.exValid);
    check1($sformatf("id_ready step %0d", idx), idReady, e.idReady);
    check1($sformatf("if_kill step %0d", idx), ifKill, e.ifKill);
  endtask

  task automatic runVec(input vec_t v, input int idx);
    @(negedge clk);
    applyStimulus(v);
    #1;
    checkOutput(idx);
  endtask

  initial begin
    //          iv er e1 a1 e2 a2 ew aw br wb wa fl  xv xr xk
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0,  1, 1, 0)); // issue write r3
    vecs.push_back(mk(1, 1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0)); // RAW on r3
    vecs.push_back(mk(1, 1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 3, 0, 0, 0, 0, 0, 1, 3, 0,  1, 1, 0)); // wb bypass frees r3
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0,  1, 1, 0)); // writer r0
    vecs.push_back(mk(1, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0)); // reader r0
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0,  1, 1, 0)); // r5 x3
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0,  1, 1, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0,  1, 1, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0,  0, 0, 0)); // r5 full
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 1, 5, 0, 1, 5, 0,  0, 0, 0)); // wb lands at edge
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0,  1, 1, 0)); // released
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 5, 0,  0, 1, 0)); // drain r5
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 5, 0,  0, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 5, 0,  0, 1, 0));
    vecs.push_back(mk(1, 1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0)); // r5 idle again
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0,  1, 1, 0)); // r7 cnt 1
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 1, 7, 0, 1, 7, 0,  1, 1, 0)); // inc+dec
    vecs.push_back(mk(1, 1, 0, 0, 1, 7, 0, 0, 0, 0, 0, 0,  0, 0, 0)); // still busy
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0,  0, 1, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0,  1, 1, 0)); // taken branch
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0,  1, 0, 0)); // branch held
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0,  1, 0, 0)); // held writer r2
    vecs.push_back(mk(1, 1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0)); // r2 untouched
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0,  1, 1, 0)); // pending r2
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 1, 9, 0, 0, 0, 0,  1, 1, 0)); // pending r9
    vecs.push_back(mk(1, 1, 1, 2, 0, 0, 0, 0, 1, 0, 0, 1,  0, 0, 0)); // flush
    vecs.push_back(mk(1, 1, 1, 2, 1, 9, 0, 0, 0, 0, 0, 0,  1, 1, 0)); // cleared
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0,  1, 1, 0)); // branch
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1,  0, 0, 1)); // flush over kill
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0));

    rstN = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check1("reset if_kill", ifKill, 1'b0);
`ifdef ISSUE_STAT_EN
    checks++;
    if (stallCycles === 32'd0) passes++;
    else $display("[TB] FAIL reset stall_cycles: got %0d, expected 0", stallCycles);
`endif
    @(negedge clk);
    rstN = 1'b1;

    $display("[TB] running %0d vectors", vecs.size());
    for (int i = 0; i < vecs.size(); i++) runVec(vecs[i], i);

`ifdef ISSUE_STAT_EN
    @(negedge clk);
    checks++;
    if (stallCycles === 32'(expStalls)) passes++;
    else $display("[TB] FAIL stall_cycles: got %0d, expected %0d", stallCycles, expStalls);
`endif

    // Asynchronous reset mid-flight: pending write to r4 and a pending kill vanish.
    runVec(mk(1, 1, 0, 0, 0, 0, 1, 4, 1, 0, 0, 0, 1, 1, 0), 100);
    @(negedge clk);
    idValid = 1'b0; rwEn = 1'b0; brTaken = 1'b0;
    #1;
    check1("kill before reset", ifKill, 1'b1);
    rstN = 1'b0;
    #1;
    check1("kill async reset", ifKill, 1'b0);
`ifdef ISSUE_STAT_EN
    checks++;
    if (stallCycles === 32'd0) passes++;
    else $display("[TB] FAIL stall_cycles after reset: got %0d, expected 0", stallCycles);
`endif
    #1;
    rstN = 1'b1;
    runVec(mk(1, 1, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0), 101);
    runVec(mk(1, 1, 0, 0, 1, 4, 0, 0, 0, 0, 0, 0, 1, 1, 0), 102);

    checks++;
    if (sbQueue.size() == 0) passes++;
    else $display("[TB] FAIL scoreboard drain: got %0d entries, expected 0", sbQueue.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
